uart_port: RTL and testbench

Serial-port responder on the RAM1 data bus: the device end of the `rdn`/`wrn`/`data_ready`/`tbre`/`tsre` handshake that the CPU-side RAM1/UART controller drives. Bus writes load a transmit holding register that is shifted out on `txd_o` as 8N1 frames. Received frames are pushed into a small RX FIFO that bus reads pop. The block replaces the external UART chip in simulation and in FPGA-only builds.

---
 rtl/uart_port.sv | 217 +++++++++++++++++++++
 tb/tb_uart_port.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_port.sv
// uart_port: device end of the RAM1-bus serial port handshake.
//   Bus writes (wrn_i strobe) load a transmit holding register that is sent
//   on txd_o as 8N1 frames. Frames received on rxd_i are queued in a small
//   RX FIFO that bus reads (rdn_i strobe) pop.
// Ports:
//   clk, rst           single clock, synchronous active-high reset
//   rdn_i, wrn_i       async active-low bus strobes; an access ends on the
//                      rising edge of the synchronized strobe
//   data_i[15:0]       write data, only [7:0] used
//   data_o[15:0]       registered read data {8'h00, fifo head}, 0 when empty
//   data_oe_o          bus drive enable, !rdn_i
//   data_ready_o       RX FIFO non-empty (registered)
//   tbre_o, tsre_o     transmit holding register empty / shifter empty
//   rxd_i, txd_o       serial lines, idle high
module uart_port #(
  parameter int CLKS_PER_BIT = 96,
  parameter int RX_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdn_i,
  input  logic        wrn_i,
  input  logic [15:0] data_i,
  output logic [15:0] data_o,
  output logic        data_oe_o,
  output logic        data_ready_o,
  output logic        tbre_o,
  output logic        tsre_o,
  input  logic        rxd_i,
  output logic        txd_o
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int AW = $clog2(RX_DEPTH);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(RX_DEPTH);

  // ---------------- synchronizers and strobe edge detect ----------------
  // [0],[1] form the 2-FF synchronizer; [2] is the previous synchronized
  // value used to find the 0->1 edge that ends an access.
  logic [2:0] rdn_sy, wrn_sy;
  logic [1:0] rxd_sy;
  logic       rd_end, wr_end, rxd_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      rdn_sy <= '1;
      wrn_sy <= '1;
      rxd_sy <= '1;
    end else begin
      rdn_sy <= {rdn_sy[1:0], rdn_i};
      wrn_sy <= {wrn_sy[1:0], wrn_i};
      rxd_sy <= {rxd_sy[0], rxd_i};
    end
  end

  assign rd_end    = rdn_sy[1] & ~rdn_sy[2];
  assign wr_end    = wrn_sy[1] & ~wrn_sy[2];
  assign rxd_s     = rxd_sy[1];
  assign data_oe_o = ~rdn_i;

  logic unused_hi;
  assign unused_hi = ^data_i[15:8];

  // ---------------- write capture ----------------
  logic [7:0] cap;

  always_ff @(posedge clk) begin
    if (rst)             cap <= '0;
    else if (!wrn_sy[1]) cap <= data_i[7:0];
  end

  // ---------------- transmitter ----------------
  typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;
  tx_state_t     tx_q, tx_d;
  logic [7:0]    thr;
  logic [9:0]    tx_sh;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;
  logic          tx_load, tx_done, tx_bit_end;

  always_comb begin
    tx_d       = tx_q;
    tx_load    = 1'b0;
    tx_done    = 1'b0;
    tx_bit_end = (tx_cnt == BIT_LAST);
    case (tx_q)
      TX_IDLE: if (!tbre_o) begin
        tx_load = 1'b1;
        tx_d    = TX_SHIFT;
      end
      TX_SHIFT: if (tx_bit_end && tx_bit == 4'd9) begin
        // Stop bit finished: chain straight into a pending THR so that
        // back-to-back frames have no idle gap.
        if (!tbre_o) tx_load = 1'b1;
        else begin
          tx_done = 1'b1;
          tx_d    = TX_IDLE;
        end
      end
      default: tx_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_q   <= TX_IDLE;
      tx_sh  <= '1;
      tx_cnt <= '0;
      tx_bit <= '0;
      thr    <= '0;
      tbre_o <= 1'b1;
      tsre_o <= 1'b1;
    end else begin
      tx_q <= tx_d;
      if (tx_load) begin
        tx_sh  <= {1'b1, thr, 1'b0};
        tx_cnt <= '0;
        tx_bit <= '0;
        tbre_o <= 1'b1;
        tsre_o <= 1'b0;
      end else if (tx_q == TX_SHIFT) begin
        if (tx_bit_end) begin
          tx_cnt <= '0;
          tx_bit <= tx_bit + 4'd1;
          tx_sh  <= {1'b1, tx_sh[9:1]};
        end else begin
          tx_cnt <= tx_cnt + 1'b1;
        end
      end
      if (tx_done) tsre_o <= 1'b1;
      // Load and write-end are exclusive: one needs tbre=0, the other tbre=1.
      if (wr_end && tbre_o) begin
        thr    <= cap;
        tbre_o <= 1'b0;
      end
    end
  end

  assign txd_o = tx_sh[0];

  // ---------------- receiver ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  rx_state_t     rx_q, rx_d;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_sh;
  logic          rx_push, rx_bit_hit, rx_half_hit;

  always_comb begin
    rx_d        = rx_q;
    rx_push     = 1'b0;
    rx_bit_hit  = (rx_cnt == BIT_LAST);
    rx_half_hit = (rx_cnt == HALF_LAST);
    case (rx_q)
      RX_IDLE:  if (!rxd_s) rx_d = RX_START;
      RX_START: if (rx_half_hit) rx_d = rxd_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_bit_hit && rx_bit == 3'd7) rx_d = RX_STOP;
      RX_STOP:  if (rx_bit_hit) begin
        rx_d    = RX_IDLE;
        rx_push = rxd_s;      // stop bit 0 is a framing error: drop byte
      end
      default:  rx_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_q   <= RX_IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh  <= '0;
    end else begin
      rx_q <= rx_d;
      // Counter restarts on every state change, so START measures half a
      // bit and every later sample lands one full bit after the previous.
      if (rx_q == RX_IDLE || rx_d != rx_q || rx_bit_hit) rx_cnt <= '0;
      else                                                rx_cnt <= rx_cnt + 1'b1;
      if (rx_q == RX_START) rx_bit <= '0;
      if (rx_q == RX_DATA && rx_bit_hit) begin
        rx_sh  <= {rxd_s, rx_sh[7:1]};
        rx_bit <= rx_bit + 3'd1;
      end
    end
  end

  // ---------------- RX FIFO and read port ----------------
  logic [7:0] mem [RX_DEPTH];
  logic [AW:0] wptr, rptr, fifo_cnt;
  logic        empty, full, pop, push_ok;

  assign fifo_cnt = wptr - rptr;
  assign empty    = (wptr == rptr);
  assign full     = (fifo_cnt == FULL_CNT);
  assign pop      = rd_end & ~empty;
  // When full, a same-cycle pop frees the head slot, which is exactly the
  // slot the write pointer addresses.
  assign push_ok  = rx_push & (~full | pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[AW-1:0]] <= rx_sh;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr         <= '0;
      rptr         <= '0;
      data_o       <= '0;
      data_ready_o <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      data_ready_o <= ~empty;
      data_o       <= empty ? 16'h0000 : {8'h00, mem[rptr[AW-1:0]]};
    end
  end
endmodule

// File: tb/tb_uart_port.sv
// Self-checking bench for uart_port. TX frames are decoded by a line monitor
// and checked against a queue of expected bytes; RX bytes are queued when a
// frame is driven and checked when a bus read returns them.
module tb_uart_port;
  localparam int CPB   = 8;
  localparam int DEPTH = 4;
  localparam int HALF  = CPB / 2;

  logic        clk = 1'b0;
  logic        rst, rdn_i, wrn_i, rxd_i;
  logic [15:0] data_i, data_o;
  logic        data_oe_o, data_ready_o, tbre_o, tsre_o, txd_o;

  uart_port #(.CLKS_PER_BIT(CPB), .RX_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rdn_i(rdn_i), .wrn_i(wrn_i), .data_i(data_i),
    .data_o(data_o), .data_oe_o(data_oe_o), .data_ready_o(data_ready_o),
    .tbre_o(tbre_o), .tsre_o(tsre_o), .rxd_i(rxd_i), .txd_o(txd_o)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // ---------------- TX line monitor ----------------
  int unsigned start_prev = 0, start_last = 0;
  int          n_frames = 0;
  bit          tx_mon_on = 1'b1;

  initial begin : tx_mon
    logic       prev;
    logic [9:0] mid, e0, e1, expf;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev && !txd_o && !rst && tx_mon_on) begin
        start_prev = start_last;
        start_last = cyc;
        n_frames++;
        for (int b = 0; b < 10; b++) begin
          for (int c = 0; c < CPB; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (c == 0)       e0[b]  = txd_o;
            if (c == HALF)    mid[b] = txd_o;
            if (c == CPB - 1) e1[b]  = txd_o;
          end
        end
        expf = (exp_tx.size() != 0) ? {1'b1, exp_tx.pop_front(), 1'b0} : 10'h3FF;
        chk("tx_frame", mid, expf);
        chk("tx_bit_timing", {e0, e1}, {mid, mid});
      end
      prev = txd_o;
    end
  end

  // ---------------- bus / line drivers ----------------
  task automatic bus_write(input logic [7:0] d);
    @(negedge clk);
    data_i = {8'h12, d};
    wrn_i  = 1'b0;
    repeat (3) @(negedge clk);
    wrn_i = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic bus_read();
    logic [15:0] exp;
    @(negedge clk);
    rdn_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("data_oe_low", data_oe_o, 1'b1);
    exp = (exp_rx.size() != 0) ? {8'h00, exp_rx.pop_front()} : 16'h0000;
    chk("read_data", data_o, exp);
    @(negedge clk);
    chk("read_data_hold", data_o, exp);
    rdn_i = 1'b1;
    repeat (5) @(negedge clk);
    chk("data_oe_high", data_oe_o, 1'b0);
    chk("read_ready_after", data_ready_o, exp_rx.size() != 0);
    chk("read_data_after", data_o, (exp_rx.size() != 0) ? {8'h00, exp_rx[0]} : 16'h0000);
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      @(negedge clk);
      rxd_i = f[b];
      repeat (CPB - 1) @(negedge clk);
    end
    @(negedge clk);
    rxd_i = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic wait_tsre(input int lim);
    int w;
    w = 0;
    while (!tsre_o && w < lim) begin
      @(negedge clk);
      w++;
    end
    chk("tsre_wait", tsre_o, 1'b1);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       push;
  } rx_vec_t;

  rx_vec_t tab [6];

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int unsigned t0;
    tab[0] = '{8'hA5, 1'b1, 1'b1};
    tab[1] = '{8'h3C, 1'b1, 1'b1};
    tab[2] = '{8'h00, 1'b1, 1'b1};
    tab[3] = '{8'hFF, 1'b1, 1'b1};
    tab[4] = '{8'h5A, 1'b0, 1'b0};
    tab[5] = '{8'h81, 1'b1, 1'b1};

    rst = 1'b1; rdn_i = 1'b1; wrn_i = 1'b1; rxd_i = 1'b1; data_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_txd", txd_o, 1'b1);
    chk("rst_tbre", tbre_o, 1'b1);
    chk("rst_tsre", tsre_o, 1'b1);
    chk("rst_ready", data_ready_o, 1'b0);
    chk("rst_data", data_o, 16'h0000);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single TX of 16'h1255: bus_write puts 8'h12 on the upper byte.
    exp_tx.push_back(8'h55);
    bus_write(8'h55);
    chk("tx1_tbre_fall", tbre_o, 1'b0);
    @(negedge clk);
    chk("tx1_start_txd", txd_o, 1'b0);
    chk("tx1_start_tbre", tbre_o, 1'b1);
    chk("tx1_start_tsre", tsre_o, 1'b0);
    t0 = cyc;
    wait_tsre(20 * CPB);
    chk("tx1_tsre_delay", cyc - t0, 10 * CPB);
    repeat (4) @(negedge clk);

    // Back-to-back TX, third write dropped while THR is full.
    exp_tx.push_back(8'h41);
    exp_tx.push_back(8'h42);
    bus_write(8'h41);
    @(negedge clk);
    chk("b2b_first_busy", tsre_o, 1'b0);
    bus_write(8'h42);
    chk("b2b_tbre_full", tbre_o, 1'b0);
    bus_write(8'h43);
    chk("b2b_tbre_still_full", tbre_o, 1'b0);
    wait_tsre(30 * CPB);
    repeat (2) @(negedge clk);
    chk("b2b_no_gap", start_last - start_prev, 10 * CPB);
    chk("tx_frame_count", n_frames, 3);
    chk("tx_queue_drained", exp_tx.size(), 0);

    // RX table.
    for (int i = 0; i < 6; i++) begin
      if (tab[i].push) exp_rx.push_back(tab[i].d);
      send_rx(tab[i].d, tab[i].stop);
      chk("rx_ready", data_ready_o, tab[i].push);
      chk("rx_data_o", data_o, tab[i].push ? {8'h00, tab[i].d} : 16'h0000);
      if (tab[i].push) bus_read();
    end

    // Overflow: fifth byte dropped.
    for (int i = 1; i <= 5; i++) begin
      if (i <= DEPTH) exp_rx.push_back(8'(i));
      send_rx(8'(i), 1'b1);
    end
    chk("ovf_ready", data_ready_o, 1'b1);
    for (int i = 0; i < DEPTH; i++) bus_read();
    chk("ovf_empty_ready", data_ready_o, 1'b0);
    bus_read();

    // Push into a full FIFO on the same cycle as a pop: byte accepted.
    for (int i = 0; i < DEPTH; i++) begin
      exp_rx.push_back(8'h11 + 8'(i));
      send_rx(8'h11 + 8'(i), 1'b1);
    end
    exp_rx.push_back(8'h15);
    fork
      send_rx(8'h15, 1'b1);
      begin
        // Read-end lands on the stop-bit sample cycle of the frame above.
        repeat (HALF + 9 * CPB - 3) @(negedge clk);
        rdn_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("conc_read_data", data_o, {8'h00, exp_rx.pop_front()});
        repeat (2) @(negedge clk);
        rdn_i = 1'b1;
      end
    join
    chk("conc_ready", data_ready_o, 1'b1);
    for (int i = 0; i < DEPTH; i++) bus_read();
    bus_read();

    // Short glitch on rxd: no push.
    @(negedge clk);
    rxd_i = 1'b0;
    repeat (HALF - 2) @(negedge clk);
    rxd_i = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    chk("glitch_ready", data_ready_o, 1'b0);
    chk("glitch_data", data_o, 16'h0000);

    // Reset during a TX data bit.
    tx_mon_on = 1'b0;
    bus_write(8'h00);
    repeat (CPB + 3) @(negedge clk);
    chk("rstmid_bit_low", txd_o, 1'b0);
    chk("rstmid_busy", tsre_o, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_txd", txd_o, 1'b1);
    chk("rstmid_tbre", tbre_o, 1'b1);
    chk("rstmid_tsre", tsre_o, 1'b1);
    rst = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    chk("rstmid_idle_txd", txd_o, 1'b1);
    tx_mon_on = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
